// File: rtl/rot_load_ctrl_pkg.sv
// Shared types and default sizes for the rotate-register load controller.
// Optional flush port is enabled by defining ROT_LOAD_CTRL_FLUSH_EN.
package rot_load_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROTATE
  } rlc_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_HOLD  = 8;

endpackage

// File: rtl/rot_load_ctrl_if.sv
// Producer-side valid/ready word handshake feeding rot_load_ctrl.
interface rot_load_ctrl_if
  import rot_load_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master(output in_data, output in_valid, input in_ready);
  modport slave (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/rot_load_ctrl_fifo.sv
// Small synchronous FIFO with occupancy count; clear has priority over push/pop.
module sync_fifo
  import rot_load_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rot_load_ctrl.sv
// Feeds a rotate-left register: buffers words, issues one-cycle load pulses spaced HOLD+1 apart.
// Define ROT_LOAD_CTRL_FLUSH_EN to add a synchronous flush input.
module rot_load_ctrl
  import rot_load_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic                       clk,
  input  logic                       rstn,
`ifdef ROT_LOAD_CTRL_FLUSH_EN
  input  logic                       flush,
`endif
  rot_load_ctrl_if.slave             in_if,
  output logic [WIDTH-1:0]           load_val,
  output logic                       load_en,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int HW = $clog2(HOLD + 1);
  localparam int CW = $clog2(DEPTH + 1);

  rlc_state_t       r_state;
  rlc_state_t       w_state_nxt;
  logic [HW-1:0]    r_hold_cnt;
  logic [WIDTH-1:0] r_load_val;
  logic             r_load_en;

  logic             w_flush;
  logic             w_push;
  logic             w_pop;
  logic             w_hold_last;
  logic [WIDTH-1:0] w_head;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;

`ifdef ROT_LOAD_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // No pass-through: a full FIFO refuses even when a pop happens on the same edge.
  assign in_if.in_ready = rstn && !w_full && !w_flush;
  assign w_push         = in_if.in_valid && in_if.in_ready;
  assign w_hold_last    = (r_hold_cnt == HW'(HOLD - 1));

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_if.in_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = LOAD;
          w_pop       = 1'b1;
        end
      end
      LOAD: w_state_nxt = ROTATE;
      ROTATE: begin
        if (w_hold_last) begin
          if (!w_empty) begin
            w_state_nxt = LOAD;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_load_val <= '0;
      r_load_en  <= 1'b0;
    end else if (w_flush) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_load_en  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // Every pop is an entry into LOAD, so the pop doubles as the load strobe.
      r_load_en <= w_pop;
      if (w_pop) r_load_val <= w_head;
      if (r_state == LOAD) begin
        r_hold_cnt <= '0;
      end else if (r_state == ROTATE && !w_hold_last) begin
        r_hold_cnt <= r_hold_cnt + HW'(1);
      end
    end
  end

  assign load_val = r_load_val;
  assign load_en  = r_load_en;
  assign busy     = (r_state != IDLE);
  assign count    = w_count;

endmodule
